fofb_setpoint_capture: RTL and testbench
========================================

# fofb_setpoint_capture

Captures the per-FA-cycle power-supply setpoint AXI stream produced by `fofbDSP` into a double-buffered register bank in the `sysClk` domain. Each completed frame is validated for word count, TLAST position and arrival time relative to `sysFAstrobe`. The last good frame is exposed on a random-access readout port for the microBlaze/GPIO path, together with frame, error and latency counters. The block sits directly downstream of `fofbDSP` and in parallel with the power-supply transmitter.

## Interface
- `RESULT_COUNT`, 24: setpoint words per frame (GPIO_CHANNEL_COUNT).
- `ADDR_WIDTH`, 5: readout address width; 2^ADDR_WIDTH ≥ RESULT_COUNT.
- `TIMEOUT_CYCLES`, 10000: sysClk cycles from strobe to required frame completion (100 µs).

- `sysClk` in 1: system clock (100 MHz); the only clock.
- `sysReset` in 1: asynchronous, active-high reset.
- `sysFAstrobe` in 1: single-cycle fast-acquisition strobe, synchronous to sysClk.
- `SETPOINT_TVALID` in 1: stream valid. There is no TREADY; every valid beat is accepted.
- `SETPOINT_TLAST` in 1: last word of frame.
- `SETPOINT_TDATA` in 32: setpoint word.
- `readAddress` in ADDR_WIDTH: readout word index.
- `readData` out 32: committed word at readAddress, 1-cycle latency.
- `frameValid` out 1: at least one good frame has been committed since reset.
- `frameCount` out 32: good frames committed; wraps.
- `errorCount` out 16: bad or aborted frames; saturates at 0xFFFF.
- `latency` out 16: strobe-to-TLAST cycles of the last good frame; saturates at 0xFFFF.
- `statusStrobe` out 1: one-cycle pulse on each frame outcome.
- `statusCode` out 3: outcome code; held until the next statusStrobe.
- `busy` out 1: high in ARMED or RECEIVING.

## Operation
- **States**
  - IDLE: waiting for a strobe.
  - ARMED: strobe seen, no beat yet.
  - RECEIVING: ≥1 beat received.
  - DRAIN: discarding beats until TLAST.
- **Word counter `wIdx`**
  - Cleared on strobe.
  - Increments on each valid beat in ARMED/RECEIVING.
  - Beat data is written to `shadow[wIdx]`, where `shadow = bank[~bankSel]`.
- **IDLE transitions**
  - Strobe → ARMED. The timeout counter clears; the latency counter clears and starts.
- **ARMED / RECEIVING beat with TLAST**
  - If `wIdx == RESULT_COUNT-1`: commit (`bankSel` toggles, `frameValid` set, `frameCount++`, `latency` latched), code 0 OK → IDLE.
  - If `wIdx < RESULT_COUNT-1`: code 1 SHORT → IDLE; no commit.
- **ARMED / RECEIVING beat without TLAST**
  - If `wIdx == RESULT_COUNT-1`: code 2 LONG → DRAIN.
- **DRAIN**
  - Discards beats.
  - A beat with TLAST → IDLE; no further status.
  - Timeout still applies: code 3 → IDLE.
- **Timeout**
  - In ARMED/RECEIVING, the timeout counter reaching TIMEOUT_CYCLES-1 gives code 3 TIMEOUT → IDLE.
- **Unsolicited data**
  - A valid beat in IDLE gives code 4 UNSOLICITED.
  - If the beat lacks TLAST, the block enters DRAIN.
- **Overrun**
  - A strobe in ARMED/RECEIVING/DRAIN gives code 5 OVERRUN.
  - The current frame is aborted and the block restarts in ARMED (counters cleared) on the same edge.
- **Error counting**
  - Every code 1–5 increments `errorCount` (saturating).
  - Code 0 does not.
- **Readout**
  - `readData` ← `bank[bankSel][readAddress]`.
  - Returns 0 if `readAddress ≥ RESULT_COUNT` or `!frameValid`.

## Timing
- **Reset values**
  - State IDLE.
  - `bankSel` 0, `frameValid` 0.
  - `readData` 0.
  - All counters 0.
  - `statusStrobe` 0, `statusCode` 0, `busy` 0.
  - Bank contents are not reset; masking is done by `frameValid`.
- **Reset mid-frame:** the frame is discarded and no status is issued.
- **Status timing:** `statusStrobe`/`statusCode` register on the edge that processes the deciding beat, strobe or timeout. The pulse is visible in the following cycle.
- **Commit visibility**
  - A read sampled on the commit edge returns the old frame.
  - A read sampled on the next edge returns the new frame.
- **Latency definition**
  - Latency = number of sysClk edges from the strobe edge to the TLAST edge.
  - A strobe at edge N with TLAST sampled at edge N+k gives `latency = k`.
- **Simultaneous strobe and beat in IDLE:** the strobe wins. The beat is treated as word 0 of the new frame.
- **Simultaneous strobe and beat in an active state:** OVERRUN is reported, and the beat becomes word 0 of the new frame.
- **Strobe at the timeout edge:** OVERRUN is reported (not TIMEOUT).
- **TVALID gaps:** allowed anywhere within a frame.

## Test plan
- **Good frame:** strobe, then 24 contiguous beats of `TDATA = 0x1000+i` with TLAST on i=23 → code 0; `frameCount=1`; `readData(5)=0x1005`; `readAddress=30` reads 0.
- **Short frame:** 10 beats with TLAST on the 10th → code 1; `errorCount=1`; `readData` still shows the previous frame; `frameCount` unchanged.
- **Long frame:** 26 beats with TLAST on the 26th → code 2 after beat 24; DRAIN absorbs beats 25–26; IDLE afterwards; no commit.
- **Timeout:** with `TIMEOUT_CYCLES=50`, strobe with no data → code 3 exactly 50 cycles after the strobe edge; `busy` falls.
- **Overrun and unsolicited:**
  - Strobe after 12 beats → code 5, then a full 24-beat frame commits OK.
  - A lone beat in IDLE with TLAST → code 4.
  - `errorCount` ends at 2.
- **Latency and reset:**
  - Strobe, 3 idle cycles, then 24 beats → `latency=27`.
  - Assert `sysReset` mid-frame → all outputs 0, `frameValid=0`.

Source files
------------

// File: rtl/fofb_setpoint_capture_if.sv
// Setpoint AXI stream from fofbDSP. There is no TREADY, so every valid beat is taken.
interface fofb_setpoint_capture_if;
  logic        tvalid;
  logic        tlast;
  logic [31:0] tdata;

  modport master (output tvalid, tlast, tdata);
  modport slave  (input  tvalid, tlast, tdata);
endinterface

// File: rtl/fofb_setpoint_capture.sv
// Captures per-FA-cycle setpoint frames into a double-buffered bank, validates length and timing,
// and exposes the last good frame plus frame/error/latency counters.
module fofb_setpoint_capture #(
  parameter int RESULT_COUNT   = 24,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fa_strobe,
  fofb_setpoint_capture_if.slave  setpoint,
  input  logic [ADDR_WIDTH-1:0]   read_address,
  output logic [31:0]             read_data,
  output logic                    frame_valid,
  output logic [31:0]             frame_count,
  output logic [15:0]             error_count,
  output logic [15:0]             latency,
  output logic                    status_strobe,
  output logic [2:0]              status_code,
  output logic                    busy
);
  // state     | meaning
  // IDLE      | waiting for a strobe
  // ARMED     | strobe seen, no beat yet
  // RECEIVING | at least one beat of the frame received
  // DRAIN     | discarding beats until TLAST

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RESULT_COUNT - 1);
  localparam logic [TW-1:0]         TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] C_OK      = 3'd0;
  localparam logic [2:0] C_SHORT   = 3'd1;
  localparam logic [2:0] C_LONG    = 3'd2;
  localparam logic [2:0] C_TIMEOUT = 3'd3;
  localparam logic [2:0] C_UNSOL   = 3'd4;
  localparam logic [2:0] C_OVERRUN = 3'd5;

  typedef enum logic [1:0] {IDLE, ARMED, RECEIVING, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [TW-1:0]         tmr;
  logic [15:0]           lat_cnt;
  logic                  bank_sel;
  logic [31:0]           bank [2][RESULT_COUNT];

  logic                  beat;
  logic                  active;
  logic                  tmr_done;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;

  assign beat     = setpoint.tvalid;
  assign active   = (state == ARMED) || (state == RECEIVING);
  assign tmr_done = (tmr == '0);
  assign wr_en    = beat && (fa_strobe || active);
  assign wr_idx   = fa_strobe ? '0 : w_idx;
  assign busy     = active;

  // Shadow bank is the one not being read; contents are masked by frame_valid, not reset.
  always_ff @(posedge clk) begin
    if (wr_en) bank[~bank_sel][wr_idx] <= setpoint.tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      w_idx         <= '0;
      tmr           <= '0;
      lat_cnt       <= '0;
      bank_sel      <= 1'b0;
      frame_valid   <= 1'b0;
      frame_count   <= '0;
      latency       <= '0;
      status_strobe <= 1'b0;
      status_code   <= C_OK;
    end else begin
      status_strobe <= 1'b0;
      if (lat_cnt != 16'hFFFF) lat_cnt <= lat_cnt + 16'd1;
      if (!tmr_done) tmr <= tmr - 1'b1;

      if (fa_strobe) begin
        state   <= ARMED;
        w_idx   <= '0;
        tmr     <= TMR_LOAD;
        lat_cnt <= '0;
        if (state != IDLE) begin
          status_strobe <= 1'b1;
          status_code   <= C_OVERRUN;
        end
        // A beat on the strobe edge is word 0 of the new frame; TLAST on it makes the frame short.
        if (beat) begin
          w_idx <= ADDR_WIDTH'(1);
          state <= RECEIVING;
          if (setpoint.tlast) begin
            state <= IDLE;
            if (state == IDLE) begin
              status_strobe <= 1'b1;
              status_code   <= C_SHORT;
            end
          end
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (beat) begin
              status_strobe <= 1'b1;
              status_code   <= C_UNSOL;
              tmr           <= TMR_LOAD;
              if (!setpoint.tlast) state <= DRAIN;
            end
          end
          ARMED, RECEIVING: begin
            if (tmr_done) begin
              status_strobe <= 1'b1;
              status_code   <= C_TIMEOUT;
              state         <= IDLE;
            end else if (beat) begin
              if (setpoint.tlast) begin
                state         <= IDLE;
                status_strobe <= 1'b1;
                if (w_idx == LAST_IDX) begin
                  status_code <= C_OK;
                  bank_sel    <= ~bank_sel;
                  frame_valid <= 1'b1;
                  frame_count <= frame_count + 32'd1;
                  latency     <= (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;
                end else begin
                  status_code <= C_SHORT;
                end
              end else if (w_idx == LAST_IDX) begin
                status_strobe <= 1'b1;
                status_code   <= C_LONG;
                state         <= DRAIN;
              end else begin
                w_idx <= w_idx + 1'b1;
                state <= RECEIVING;
              end
            end
          end
          DRAIN: begin
            if (beat && setpoint.tlast) begin
              state <= IDLE;
            end else if (tmr_done) begin
              status_strobe <= 1'b1;
              status_code   <= C_TIMEOUT;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Errors are counted from the registered outcome, one cycle behind the status pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_count <= '0;
    end else if (status_strobe && (status_code != C_OK) && (error_count != 16'hFFFF)) begin
      error_count <= error_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (!frame_valid ||
                 ({{(32-ADDR_WIDTH){1'b0}}, read_address} >= 32'(RESULT_COUNT))) begin
      read_data <= '0;
    end else begin
      read_data <= bank[bank_sel][read_address];
    end
  end
endmodule

// File: tb/tb_fofb_setpoint_capture.sv
// Directed bench for fofb_setpoint_capture with hand-computed expectations (timeout set to 50 cycles).
module tb_fofb_setpoint_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fa_strobe = 1'b0;
  logic [4:0]  read_address = '0;
  logic [31:0] read_data;
  logic        frame_valid;
  logic [31:0] frame_count;
  logic [15:0] error_count;
  logic [15:0] latency;
  logic        status_strobe;
  logic [2:0]  status_code;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int n_stat = 0;
  int n0 = 0;

  fofb_setpoint_capture_if sp();

  fofb_setpoint_capture #(
    .RESULT_COUNT(24),
    .ADDR_WIDTH(5),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fa_strobe(fa_strobe),
    .setpoint(sp.slave),
    .read_address(read_address),
    .read_data(read_data),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .error_count(error_count),
    .latency(latency),
    .status_strobe(status_strobe),
    .status_code(status_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (status_strobe) n_stat++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic strobe();
    fa_strobe = 1'b1;
    tick();
    fa_strobe = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    sp.tvalid = 1'b1;
    sp.tdata  = d;
    sp.tlast  = last;
    tick();
    sp.tvalid = 1'b0;
    sp.tlast  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) send(base + 32'(i), i == n - 1);
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    read_address = a;
    tick();
    check(tag, read_data, exp);
  endtask

  initial begin
    sp.tvalid = 1'b0;
    sp.tlast  = 1'b0;
    sp.tdata  = '0;
    repeat (3) tick();

    check("rst_read_data", read_data, 0);
    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_error_count", 32'(error_count), 0);
    check("rst_latency", 32'(latency), 0);
    check("rst_status", {28'd0, status_strobe, status_code}, 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // good frame
    strobe();
    check("good_busy_armed", 32'(busy), 1);
    send_frame(32'h1000, 24);
    check("good_strobe", 32'(status_strobe), 1);
    check("good_code", 32'(status_code), 0);
    check("good_frame_count", frame_count, 1);
    check("good_frame_valid", 32'(frame_valid), 1);
    check("good_latency", 32'(latency), 24);
    check("good_busy_done", 32'(busy), 0);
    rd("good_rd5", 5'd5, 32'h1005);
    rd("good_rd23", 5'd23, 32'h1017);
    rd("good_rd30", 5'd30, 0);

    // short frame
    strobe();
    send_frame(32'h2000, 10);
    check("short_strobe", 32'(status_strobe), 1);
    check("short_code", 32'(status_code), 1);
    tick();
    check("short_error_count", 32'(error_count), 1);
    check("short_frame_count", frame_count, 1);
    rd("short_rd5", 5'd5, 32'h1005);
    rd("short_rd0", 5'd0, 32'h1000);

    // long frame
    n0 = n_stat;
    strobe();
    for (int i = 0; i < 24; i++) send(32'h3000 + 32'(i), 1'b0);
    check("long_strobe", 32'(status_strobe), 1);
    check("long_code", 32'(status_code), 2);
    check("long_busy_drain", 32'(busy), 0);
    send(32'h3018, 1'b0);
    check("long_drain_beat25", 32'(status_strobe), 0);
    send(32'h3019, 1'b1);
    check("long_drain_beat26", 32'(status_strobe), 0);
    tick();
    check("long_error_count", 32'(error_count), 2);
    check("long_frame_count", frame_count, 1);
    check("long_one_status", 32'(n_stat - n0), 1);
    rd("long_rd5", 5'd5, 32'h1005);

    // timeout (also shows DRAIN returned to IDLE: no overrun on this strobe)
    strobe();
    check("timeout_no_overrun", 32'(status_strobe), 0);
    repeat (49) tick();
    check("timeout_early", 32'(status_strobe), 0);
    check("timeout_busy_before", 32'(busy), 1);
    tick();
    check("timeout_strobe", 32'(status_strobe), 1);
    check("timeout_code", 32'(status_code), 3);
    check("timeout_busy_after", 32'(busy), 0);
    tick();
    check("timeout_error_count", 32'(error_count), 3);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // overrun then good frame
    strobe();
    for (int i = 0; i < 12; i++) send(32'h7000 + 32'(i), 1'b0);
    strobe();
    check("overrun_strobe", 32'(status_strobe), 1);
    check("overrun_code", 32'(status_code), 5);
    check("overrun_busy", 32'(busy), 1);
    send_frame(32'h4000, 24);
    check("overrun_next_code", 32'(status_code), 0);
    check("overrun_next_count", frame_count, 1);
    check("overrun_next_latency", 32'(latency), 24);
    rd("overrun_rd5", 5'd5, 32'h4005);

    // unsolicited beat in IDLE
    send(32'h8000, 1'b1);
    check("unsol_strobe", 32'(status_strobe), 1);
    check("unsol_code", 32'(status_code), 4);
    tick();
    check("unsol_error_count", 32'(error_count), 2);
    check("unsol_frame_count", frame_count, 1);

    // latency with idle gap, commit visibility on word 7
    read_address = 5'd7;
    strobe();
    repeat (3) tick();
    for (int i = 0; i < 23; i++) send(32'h5000 + 32'(i), 1'b0);
    check("commit_before", read_data, 32'h4007);
    send(32'h5017, 1'b1);
    check("commit_edge_old", read_data, 32'h4007);
    check("latency_27", 32'(latency), 27);
    check("latency_code", 32'(status_code), 0);
    tick();
    check("commit_next_new", read_data, 32'h5007);
    check("latency_frame_count", frame_count, 2);

    // strobe and first beat on the same edge
    fa_strobe = 1'b1;
    send(32'h6000, 1'b0);
    fa_strobe = 1'b0;
    for (int i = 1; i < 24; i++) send(32'h6000 + 32'(i), i == 23);
    check("simul_code", {28'd0, status_strobe, status_code}, 32'h8);
    check("simul_latency", 32'(latency), 23);
    check("simul_frame_count", frame_count, 3);
    rd("simul_rd0", 5'd0, 32'h6000);
    rd("simul_rd23", 5'd23, 32'h6017);

    // reset mid-frame
    strobe();
    for (int i = 0; i < 5; i++) send(32'h9000 + 32'(i), 1'b0);
    n0 = n_stat;
    #2 rst = 1'b1;
    #1;
    check("midrst_read_data", read_data, 0);
    check("midrst_frame_valid", 32'(frame_valid), 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_error_count", 32'(error_count), 0);
    check("midrst_latency", 32'(latency), 0);
    check("midrst_status", {28'd0, status_strobe, status_code}, 0);
    check("midrst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("midrst_no_status", 32'(n_stat - n0), 0);
    check("midrst_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
